// File: rtl/sysbus_mem_responder.sv
// Sysbus responder backed by an internal 64-bit word array: services 64-byte
// line reads (8 beats after LATENCY cycles) and line writes (8 acked data beats).
module sysbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 8192,  // power of two, at least 16
  parameter int unsigned LATENCY   = 4      // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned LW = AW - 3;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ACK,
    RLAT,
    RESP,
    WDATA
  } state_t;

  state_t          state, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [12:0]     tag_q, tag_d;
  logic [2:0]      beat_q, beat_d;
  logic [3:0]      lat_q, lat_d;
  logic            mem_we;
  logic            is_mem;
  logic [AW-1:0]   word_addr;
  logic [63:0]     mem [MEM_WORDS];

  assign is_mem    = (tag_q[11:8] == 4'd1);
  assign word_addr = {line_q, beat_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      line_q <= '0;
      tag_q  <= '0;
      beat_q <= '0;
      lat_q  <= '0;
    end else begin
      state  <= state_d;
      line_q <= line_d;
      tag_q  <= tag_d;
      beat_q <= beat_d;
      lat_q  <= lat_d;
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr] <= req;
  end

  always_comb begin
    state_d = state;
    line_d  = line_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    reqack  = 1'b0;
    respcyc = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqcyc) begin
          // Byte offset within the line is dropped; line index wraps at the array size.
          line_d  = req[6 +: LW];
          tag_d   = reqtag;
          beat_d  = '0;
          state_d = HDR_ACK;
        end
      end
      HDR_ACK: begin
        reqack = 1'b1;
        lat_d  = '0;
        if (tag_q[12]) state_d = (LATENCY == 1) ? RESP : RLAT;
        else           state_d = WDATA;
      end
      RLAT: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == 4'(LATENCY - 2)) state_d = RESP;
      end
      RESP: begin
        respcyc = 1'b1;
        if (respack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      WDATA: begin
        reqack = reqcyc;
        if (reqcyc) begin
          mem_we = is_mem;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp    = (respcyc && is_mem) ? mem[word_addr] : '0;
  assign resptag = tag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomized self-checking bench for sysbus_mem_responder: a line-level memory
// model predicts response beats; one compare process checks every response cycle.
module tb_sysbus_mem_responder;

  localparam int unsigned MEM_WORDS = 8192;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned LINES     = MEM_WORDS / 8;
  localparam int unsigned LW        = $clog2(LINES);

  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag),
    .respack(respack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  logic [63:0] mm [MEM_WORDS];
  int unsigned written[$];
  logic [63:0] wd [8];
  int          stall [8];
  logic [63:0] cap_d [8];
  logic [12:0] cap_t [8];
  int          cap_n;
  int          last_win;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned line_of(input logic [63:0] a);
    return int'((a >> 6) % 64'(LINES));
  endfunction

  // Single checker for all response beats.
  always @(negedge clk) begin
    if (reset && respcyc) begin
      chk(!reqack, "ack_during_resp", 64'(reqack), 64'd0);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", resp, 64'd0);
      end else begin
        chk(resp == exp_q[0].data, "resp_data", resp, exp_q[0].data);
        chk(resptag == exp_q[0].tag, "resp_tag", 64'(resptag), 64'(exp_q[0].tag));
        if (respack) begin
          if (cap_n < 8) begin
            cap_d[cap_n] = resp;
            cap_t[cap_n] = resptag;
          end
          cap_n++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic hdr(input logic [63:0] a, input logic [12:0] t);
    req = a; reqtag = t; reqcyc = 1'b1;
    #2 chk(!reqack, "hdr_no_early_ack", 64'(reqack), 64'd0);
    @(posedge clk); #1;
    reqcyc = 1'b0;
    chk(reqack, "hdr_ack", 64'(reqack), 64'd1);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [3:0] tgt, input logic [7:0] id, input bit gaps);
    int unsigned ln;
    ln = line_of(a);
    hdr(a, {1'b0, tgt, id});
    reqcyc = 1'b1; req = wd[0];
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      if (gaps && k > 0) begin
        repeat ($urandom_range(0, 2)) begin
          reqcyc = 1'b0;
          #2 chk(!reqack, "wr_gap_noack", 64'(reqack), 64'd0);
          @(posedge clk); #1;
        end
      end
      reqcyc = 1'b1; req = wd[k];
      #2 chk(reqack, "wr_beat_ack", 64'(reqack), 64'd1);
      @(posedge clk); #1;
    end
    reqcyc = 1'b0;
    #2 chk(!reqack, "wr_done_noack", 64'(reqack), 64'd0);
    @(posedge clk); #1;
    if (tgt == 4'd1) begin
      for (int k = 0; k < 8; k++) mm[ln * 8 + k] = wd[k];
      written.push_back(ln);
    end
  endtask

  task automatic do_read(input logic [63:0] a, input logic [3:0] tgt, input logic [7:0] id, input bit abort);
    int unsigned ln;
    int n, win, sum;
    beat_t b;
    ln = line_of(a);
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      b.data = (tgt == 4'd1) ? mm[ln * 8 + k] : 64'd0;
      b.tag  = {1'b1, tgt, id};
      exp_q.push_back(b);
      sum += stall[k];
    end
    cap_n = 0;
    respack = 1'b0;
    hdr(a, {1'b1, tgt, id});
    n = 0;
    while (!respcyc && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == int'(LATENCY), "rd_latency", 64'(n), 64'(LATENCY));
    if (!respcyc) begin
      exp_q.delete();
      return;
    end
    win = 0;
    for (int k = 0; k < 8; k++) begin
      if (abort && k == 3) begin
        chk(cap_n == 3, "abort_beats_before", 64'(cap_n), 64'd3);
        respack = 1'b0;
        #2 reset = 1'b0;
        #1 chk(!respcyc, "abort_respcyc_async", 64'(respcyc), 64'd0);
        chk(resp == 64'd0, "abort_resp_zero", resp, 64'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) begin
          @(posedge clk); #1;
          chk(!respcyc && !reqack, "abort_quiet", {62'd0, respcyc, reqack}, 64'd0);
        end
        return;
      end
      repeat (stall[k]) begin
        respack = 1'b0;
        @(posedge clk); #1;
        win++;
      end
      respack = 1'b1;
      @(posedge clk); #1;
      win++;
    end
    respack = 1'b0;
    last_win = win;
    chk(!respcyc, "resp_end", 64'(respcyc), 64'd0);
    chk(win == 8 + sum, "resp_window", 64'(win), 64'(8 + sum));
    chk(exp_q.size() == 0, "all_beats_seen", 64'(exp_q.size()), 64'd0);
    chk(cap_n == 8, "beat_count", 64'(cap_n), 64'd8);
  endtask

  task automatic clear_stall();
    for (int k = 0; k < 8; k++) stall[k] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, saved [8];
    logic [3:0]  tgt;
    reset = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
    clear_stall();
    repeat (3) @(posedge clk);
    #1;
    chk({reqack, respcyc} == 2'b00, "reset_ctrl", {62'd0, reqack, respcyc}, 64'd0);
    chk(resp == 64'd0, "reset_resp", resp, 64'd0);
    chk(resptag == 13'd0, "reset_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Write then read, same line.
    for (int k = 0; k < 8; k++) wd[k] = 64'h1111_0000_0000_0000 | 64'(k);
    do_write(64'h1000, 4'd1, 8'h11, 1'b0);
    do_read(64'h1000, 4'd1, 8'h5A, 1'b0);
    for (int k = 0; k < 8; k++)
      chk(cap_d[k] == (64'h1111_0000_0000_0000 | 64'(k)), "lit_wr_rd", cap_d[k], 64'h1111_0000_0000_0000 | 64'(k));
    chk(cap_t[0] == 13'h115A, "lit_tag", 64'(cap_t[0]), 64'h115A);

    // Unaligned address.
    do_read(64'h1028, 4'd1, 8'h33, 1'b0);
    chk(cap_d[0] == 64'h1111_0000_0000_0000, "lit_unaligned_b0", cap_d[0], 64'h1111_0000_0000_0000);
    chk(cap_d[7] == 64'h1111_0000_0000_0007, "lit_unaligned_b7", cap_d[7], 64'h1111_0000_0000_0007);

    // Backpressure on beats 2 and 5.
    stall[2] = 3; stall[5] = 3;
    do_read(64'h1000, 4'd1, 8'h21, 1'b0);
    chk(last_win == 14, "lit_bp_window", 64'(last_win), 64'd14);
    clear_stall();

    // Non-memory target.
    do_read(64'h1000, 4'd2, 8'h44, 1'b0);
    for (int k = 0; k < 8; k++) chk(cap_d[k] == 64'd0, "lit_nonmem_zero", cap_d[k], 64'd0);
    for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
    do_write(64'h1000, 4'd2, 8'h45, 1'b1);
    do_read(64'h1000, 4'd1, 8'h46, 1'b0);
    chk(cap_d[4] == 64'h1111_0000_0000_0004, "lit_nonmem_wr_discard", cap_d[4], 64'h1111_0000_0000_0004);

    // Address wrap at the array size.
    for (int k = 0; k < 8; k++) begin
      wd[k] = {$urandom, $urandom};
      saved[k] = wd[k];
    end
    do_write(64'h10000, 4'd1, 8'h50, 1'b1);
    do_read(64'h0, 4'd1, 8'h51, 1'b0);
    for (int k = 0; k < 8; k++) chk(cap_d[k] == saved[k], "lit_wrap", cap_d[k], saved[k]);

    // Reset during beat 3, then a normal read.
    do_read(64'h1000, 4'd1, 8'h60, 1'b1);
    do_read(64'h1000, 4'd1, 8'h61, 1'b0);
    chk(cap_d[3] == 64'h1111_0000_0000_0003, "lit_after_abort", cap_d[3], 64'h1111_0000_0000_0003);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      tgt = ($urandom_range(0, 4) == 0) ? 4'd2 : 4'd1;
      for (int k = 0; k < 8; k++) stall[k] = $urandom_range(0, 2);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
        do_write(a, tgt, 8'($urandom), 1'b1);
      end else begin
        if (tgt == 4'd1) a[6 +: LW] = LW'(written[$urandom_range(0, written.size() - 1)]);
        do_read(a, tgt, 8'($urandom), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
